axi4lite_apb3_bridge: RTL and testbench

//   AXI4-Lite slave to APB3 master bridge. It feeds the APB3 interconnect master port (PADDR/PSEL/PENABLE/

---
 rtl/axi4lite_apb3_bridge.sv | 161 ++++++++++++++++
 tb/tb_axi4lite_apb3_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_apb3_bridge.sv
// AXI4-Lite slave to APB3 master bridge: one outstanding transfer, round-robin
// read/write arbitration, and an optional PREADY timeout that forces SLVERR.
module axi4lite_apb3_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic grant_wr, grant_rd, timeout_hit, xfer_resp;
  logic [1:0] apb_resp;

  // NOTE: the ready strobes are combinational from the valids, so they are
  // gated with PRESETN to keep every output low while reset is held.
  always_comb begin
    grant_wr = PRESETN && (state_q == IDLE) && AWVALID && WVALID
               && (prio_wr_q || !ARVALID);
    grant_rd = PRESETN && (state_q == IDLE) && ARVALID && !grant_wr;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (cnt_q == CNT_LAST);
  assign apb_resp    = PSLVERR ? RESP_SLVERR : RESP_OKAY;
  assign xfer_resp   = pwrite_q ? BREADY : RREADY;

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    cnt_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          pwrite_d  = 1'b1;
          paddr_d   = AWADDR & ADDR_MASK;
          pwdata_d  = WDATA;
          prio_wr_d = ~prio_wr_q;
          state_d   = SETUP;
        end else if (grant_rd) begin
          pwrite_d  = 1'b0;
          paddr_d   = ARADDR & ADDR_MASK;
          prio_wr_d = ~prio_wr_q;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          if (pwrite_q) begin
            bresp_d = apb_resp;
          end else begin
            rdata_d = PRDATA;
            rresp_d = apb_resp;
          end
          state_d = RESP;
        end else if (timeout_hit) begin
          if (pwrite_q) begin
            bresp_d = RESP_SLVERR;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: if (xfer_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign AWREADY = grant_wr;
  assign WREADY  = grant_wr;
  assign ARREADY = grant_rd;
  assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign BVALID  = (state_q == RESP) && pwrite_q;
  assign RVALID  = (state_q == RESP) && !pwrite_q;
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4lite_apb3_bridge.sv
// Scoreboard bench for axi4lite_apb3_bridge: stimulus pushes expected APB
// transfers and AXI responses; two monitors pop and compare independently.
module tb_axi4lite_apb3_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, PRDATA = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic        BREADY = 1'b1, RREADY = 1'b1, PREADY = 1'b0, PSLVERR = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic        PSEL, PENABLE, PWRITE;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, PADDR, PWDATA;

  always #5 PCLK = ~PCLK;

  axi4lite_apb3_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { bit is_wr; logic [1:0] resp; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; bit is_wr; logic [31:0] wdata; } apb_t;
  rsp_t rsp_q[$];
  apb_t apb_q[$];

  // APB slave: PREADY rises after ws wait states unless stuck.
  int  ws = 0;
  bit  stuck = 0;
  int  acc_cnt = 0;
  always @(posedge PCLK) begin
    #1;
    if (PSEL && PENABLE) begin
      PREADY = !stuck && (acc_cnt == ws);
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end
  end

  // APB monitor: every completed transfer must match the next expectation.
  always @(negedge PCLK) begin
    if (PRESETN && PSEL && PENABLE && PREADY) begin
      if (apb_q.size() == 0) begin
        check("apb_unexpected", 1, 0);
      end else begin
        apb_t e;
        e = apb_q.pop_front();
        check("apb_paddr", PADDR, e.addr);
        check("apb_pwrite", PWRITE, e.is_wr);
        if (e.is_wr) check("apb_pwdata", PWDATA, e.wdata);
      end
    end
  end

  // Response monitor: pops on each B or R handshake.
  always @(negedge PCLK) begin
    if (PRESETN && ((BVALID && BREADY) || (RVALID && RREADY))) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_kind", {BVALID, RVALID}, {e.is_wr, !e.is_wr});
        check("rsp_code", BVALID ? BRESP : RRESP, e.resp);
        if (!e.is_wr) check("rsp_rdata", RDATA, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the grant edge.
  task automatic wait_grant(input string name, input bit want_wr);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PCLK);
      seen = AWREADY || ARREADY;
    end
    check({name, "_grant_seen"}, seen, 1);
    if (want_wr) check({name, "_grant_dir"}, {AWREADY, WREADY, ARREADY}, 3'b110);
    else         check({name, "_grant_dir"}, {AWREADY, WREADY, ARREADY}, 3'b001);
    @(posedge PCLK); #1;
  endtask

  task automatic do_write(input string name, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    rsp_q.push_back('{is_wr: 1'b1, resp: resp, data: 32'h0});
    apb_q.push_back('{addr: {addr[31:2], 2'b00}, is_wr: 1'b1, wdata: data});
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1;
    wait_grant(name, 1'b1);
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input bit apb_done);
    rsp_q.push_back('{is_wr: 1'b0, resp: resp, data: data});
    if (apb_done) apb_q.push_back('{addr: {addr[31:2], 2'b00}, is_wr: 1'b0, wdata: 32'h0});
    ARADDR = addr; ARVALID = 1'b1;
    wait_grant(name, 1'b0);
    ARVALID = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100 && rsp_q.size() != 0; i++) @(negedge PCLK);
    check({name, "_drained"}, rsp_q.size(), 0);
    @(posedge PCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;
    // Reset with all request valids high: outputs must stay zero.
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    repeat (3) @(negedge PCLK);
    check("rst_ctl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, PSEL, PENABLE, PWRITE, BRESP, RRESP}, 12'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    @(posedge PCLK); #1;

    // 1: zero-wait write, cycle-accurate phases.
    do_write("t1", 32'h0000_1004, 32'hDEAD_BEEF, 2'b00);
    @(negedge PCLK);
    check("t1_setup", {PSEL, PENABLE}, 2'b10);
    @(negedge PCLK);
    check("t1_access", {PSEL, PENABLE, PWRITE}, 3'b111);
    check("t1_paddr", PADDR, 32'h0000_1004);
    @(negedge PCLK);
    check("t1_bvalid", {BVALID, PSEL, PENABLE}, 3'b100);
    check("t1_bresp", BRESP, 2'b00);
    wait_done("t1");

    // 2: read with 3 wait states, response held under RREADY=0.
    ws = 3; PRDATA = 32'h1234_5678; RREADY = 1'b0;
    do_read("t2", 32'h0000_2000, 32'h1234_5678, 2'b00, 1'b1);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      if (PENABLE) cnt++;
      seen = RVALID;
    end
    check("t2_penable_cycles", cnt, 4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge PCLK);
      check("t2_rvalid_hold", {RVALID, RRESP}, 3'b100);
      check("t2_rdata_hold", RDATA, 32'h1234_5678);
    end
    @(posedge PCLK); #1;
    RREADY = 1'b1; ws = 0;
    wait_done("t2");

    // 3: write slave error, then a clean read; RDATA untouched by the write.
    PSLVERR = 1'b1;
    do_write("t3w", 32'h0000_3008, 32'hCAFE_F00D, 2'b10);
    wait_done("t3w");
    check("t3_rdata_kept", RDATA, 32'h1234_5678);
    PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
    do_read("t3r", 32'h0000_300C, 32'h0BAD_F00D, 2'b00, 1'b1);
    wait_done("t3r");

    // 6: unaligned read address, then reset during ACCESS aborts it.
    stuck = 1;
    ARADDR = 32'h0000_1003; ARVALID = 1'b1;
    wait_grant("t6", 1'b0);
    ARVALID = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge PCLK);
      seen = PSEL && PENABLE;
    end
    check("t6_access_seen", seen, 1);
    check("t6_paddr", PADDR, 32'h0000_1000);
    PRESETN = 1'b0;
    @(posedge PCLK); #1;
    check("t6_abort", {PSEL, PENABLE}, 2'b00);
    @(posedge PCLK); #1;
    PRESETN = 1'b1; stuck = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (RVALID || BVALID) seen = 1;
    end
    check("t6_no_response", seen, 0);
    @(posedge PCLK); #1;

    // 4: contention right after reset: write, then read wins the next contest.
    PRDATA = 32'h2222_2222;
    rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, data: 32'h0});
    rsp_q.push_back('{is_wr: 1'b0, resp: 2'b00, data: 32'h2222_2222});
    rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, data: 32'h0});
    apb_q.push_back('{addr: 32'h0000_4000, is_wr: 1'b1, wdata: 32'h1111_1111});
    apb_q.push_back('{addr: 32'h0000_4100, is_wr: 1'b0, wdata: 32'h0});
    apb_q.push_back('{addr: 32'h0000_4200, is_wr: 1'b1, wdata: 32'h3333_3333});
    AWADDR = 32'h0000_4000; WDATA = 32'h1111_1111; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h0000_4100; ARVALID = 1'b1;
    wait_grant("t4a", 1'b1);
    AWADDR = 32'h0000_4200; WDATA = 32'h3333_3333;
    wait_grant("t4b", 1'b0);
    ARVALID = 1'b0;
    wait_grant("t4c", 1'b1);
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_done("t4");

    // 5: PREADY stuck low forces SLVERR after 16 ACCESS cycles.
    stuck = 1; PRDATA = 32'hAAAA_5555;
    do_read("t5", 32'h0000_5000, 32'h0, 2'b10, 1'b0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) cnt++;
      seen = (cnt > 0) && !PSEL;
    end
    check("t5_access_cycles", cnt, 16);
    stuck = 0;
    wait_done("t5");

    check("apb_queue_empty", apb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
